// File: rtl/upower_multicycle_sequencer_if.sv
// Handshake bundle between the uPower sequencer and its datapath.
// master: IR/memory side driving inputs; slave: the sequencer.
interface upower_multicycle_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       po;
  logic             halt;
  logic             imem_ready;
  logic             dmem_ready;
  logic             branch_taken;
  logic             imem_req;
  logic             ir_we;
  logic             rf_re;
  logic             rf_we;
  logic             mem_to_reg;
  logic             alu_en;
  logic             dmem_req;
  logic             dmem_we;
  logic             pc_we;
  logic             pc_sel;
  logic             retire;
  logic [2:0]       state_o;
  logic             illegal_op;
  logic             bus_err;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output po, halt, imem_ready, dmem_ready, branch_taken,
    input  imem_req, ir_we, rf_re, rf_we, mem_to_reg,
    input  alu_en, dmem_req, dmem_we, pc_we, pc_sel,
    input  retire, state_o, illegal_op, bus_err, retire_cnt
  );

  modport slave (
    input  po, halt, imem_ready, dmem_ready, branch_taken,
    output imem_req, ir_we, rf_re, rf_we, mem_to_reg,
    output alu_en, dmem_req, dmem_we, pc_we, pc_sel,
    output retire, state_o, illegal_op, bus_err, retire_cnt
  );
endinterface

// File: rtl/upower_multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the uPower datapath.
// Ports: clk, rst_n (async low), bus (slave: opcode/ready in, strobes/traps out).
module upower_multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic clk,
  input logic rst_n,
  upower_multicycle_sequencer_if.slave bus
);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  localparam logic [2:0] C_ILL   = 3'd0;
  localparam logic [2:0] C_ALU   = 3'd1;
  localparam logic [2:0] C_LOAD  = 3'd2;
  localparam logic [2:0] C_STORE = 3'd3;
  localparam logic [2:0] C_BC    = 3'd4;
  localparam logic [2:0] C_B     = 3'd5;

  // Counter holds 0..MEM_TIMEOUT-1; the wait that would reach
  // MEM_TIMEOUT is the one that traps.
  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [2:0]       r_cls;
  logic [TW-1:0]    r_tmo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ill;
  logic             r_bus;

  logic [2:0] w_cls;
  logic [2:0] w_nstate;
  logic       w_tmo_clr;
  logic       w_tmo_inc;
  logic       w_ill_set;
  logic       w_bus_set;
  logic       w_imem_req;
  logic       w_ir_we;
  logic       w_rf_re;
  logic       w_rf_we;
  logic       w_mem_to_reg;
  logic       w_alu_en;
  logic       w_dmem_req;
  logic       w_dmem_we;
  logic       w_pc_we;
  logic       w_pc_sel;
  logic       w_retire;
  logic       w_tmo_hit;

  always_comb begin
    w_cls = C_ILL;
    unique case (1'b1)
      (bus.po == 6'd31): w_cls = C_ALU;
      (bus.po inside {6'd32, 6'd34, 6'd40, 6'd42, 6'd58}):
        w_cls = C_LOAD;
      (bus.po inside {6'd36, 6'd37, 6'd38, 6'd44, 6'd62}):
        w_cls = C_STORE;
      (bus.po == 6'd19): w_cls = C_BC;
      (bus.po == 6'd18): w_cls = C_B;
      default: w_cls = C_ILL;
    endcase
  end

  assign w_tmo_hit = (r_tmo == TMO_LAST);

  always_comb begin
    w_nstate     = r_state;
    w_tmo_clr    = 1'b0;
    w_tmo_inc    = 1'b0;
    w_ill_set    = 1'b0;
    w_bus_set    = 1'b0;
    w_imem_req   = 1'b0;
    w_ir_we      = 1'b0;
    w_rf_re      = 1'b0;
    w_rf_we      = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_en     = 1'b0;
    w_dmem_req   = 1'b0;
    w_dmem_we    = 1'b0;
    w_pc_we      = 1'b0;
    w_pc_sel     = 1'b0;
    w_retire     = 1'b0;
    unique case (r_state)
      S_RESET: begin
        w_nstate  = S_FETCH;
        w_tmo_clr = 1'b1;
      end
      S_FETCH: begin
        if (bus.halt) begin
          w_nstate = S_HALT;
        end else begin
          w_imem_req = 1'b1;
          if (bus.imem_ready) begin
            w_ir_we   = 1'b1;
            w_nstate  = S_DECODE;
            w_tmo_clr = 1'b1;
          end else if (w_tmo_hit) begin
            w_nstate  = S_ERROR;
            w_bus_set = 1'b1;
          end else begin
            w_tmo_inc = 1'b1;
          end
        end
      end
      S_DECODE: begin
        w_rf_re = 1'b1;
        if (w_cls == C_ILL) begin
          w_nstate  = S_ERROR;
          w_ill_set = 1'b1;
        end else begin
          w_nstate = S_EXEC;
        end
      end
      S_EXEC: begin
        w_alu_en = 1'b1;
        w_rf_re  = (r_cls != C_B);
        unique case (r_cls)
          C_ALU: w_nstate = S_WB;
          C_LOAD, C_STORE: begin
            w_nstate  = S_MEM;
            w_tmo_clr = 1'b1;
          end
          C_B, C_BC: begin
            w_pc_we   = 1'b1;
            w_pc_sel  = (r_cls == C_B) | bus.branch_taken;
            w_retire  = 1'b1;
            w_nstate  = S_FETCH;
            w_tmo_clr = 1'b1;
          end
          default: begin
            // Unreachable: DECODE never lets ILLEGAL through.
            w_nstate  = S_ERROR;
            w_ill_set = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (r_cls == C_STORE);
        if (bus.dmem_ready) begin
          w_tmo_clr = 1'b1;
          if (r_cls == C_STORE) begin
            w_pc_we  = 1'b1;
            w_retire = 1'b1;
            w_nstate = S_FETCH;
          end else begin
            w_nstate = S_WB;
          end
        end else if (w_tmo_hit) begin
          w_nstate  = S_ERROR;
          w_bus_set = 1'b1;
        end else begin
          w_tmo_inc = 1'b1;
        end
      end
      S_WB: begin
        w_rf_we      = 1'b1;
        w_mem_to_reg = (r_cls == C_LOAD);
        w_pc_we      = 1'b1;
        w_retire     = 1'b1;
        w_nstate     = S_FETCH;
        w_tmo_clr    = 1'b1;
      end
      S_HALT: begin
        if (!bus.halt) begin
          w_nstate  = S_FETCH;
          w_tmo_clr = 1'b1;
        end
      end
      S_ERROR: w_nstate = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RESET;
      r_cls   <= C_ILL;
      r_tmo   <= '0;
      r_cnt   <= '0;
      r_ill   <= 1'b0;
      r_bus   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      if (r_state == S_DECODE) r_cls <= w_cls;
      if (w_tmo_clr) r_tmo <= '0;
      else if (w_tmo_inc) r_tmo <= r_tmo + TW'(1);
      if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
      if (w_ill_set) r_ill <= 1'b1;
      if (w_bus_set) r_bus <= 1'b1;
    end
  end

  assign bus.imem_req   = w_imem_req;
  assign bus.ir_we      = w_ir_we;
  assign bus.rf_re      = w_rf_re;
  assign bus.rf_we      = w_rf_we;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.alu_en     = w_alu_en;
  assign bus.dmem_req   = w_dmem_req;
  assign bus.dmem_we    = w_dmem_we;
  assign bus.pc_we      = w_pc_we;
  assign bus.pc_sel     = w_pc_sel;
  assign bus.retire     = w_retire;
  assign bus.state_o    = r_state;
  assign bus.illegal_op = r_ill;
  assign bus.bus_err    = r_bus;
  assign bus.retire_cnt = r_cnt;

endmodule

// File: tb/tb_upower_multicycle_sequencer.sv
// Directed bench for upower_multicycle_sequencer.
// Vectors are {state, imem_req..retire} per cycle, hand-computed.
module tb_upower_multicycle_sequencer;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  upower_multicycle_sequencer_if #(.CNT_W(3)) u_if ();

  upower_multicycle_sequencer #(
    .MEM_TIMEOUT(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state[2:0], imem_req, ir_we, rf_re, rf_we, mem_to_reg,
  //  alu_en, dmem_req, dmem_we, pc_we, pc_sel, retire}
  wire [13:0] obs = {u_if.state_o, u_if.imem_req, u_if.ir_we,
                     u_if.rf_re, u_if.rf_we, u_if.mem_to_reg,
                     u_if.alu_en, u_if.dmem_req, u_if.dmem_we,
                     u_if.pc_we, u_if.pc_sel, u_if.retire};

  localparam logic [13:0] E_F  = {3'd1, 11'b110_0000_0000};
  localparam logic [13:0] E_FW = {3'd1, 11'b100_0000_0000};
  localparam logic [13:0] E_D  = {3'd2, 11'b001_0000_0000};
  localparam logic [13:0] E_X  = {3'd3, 11'b001_0010_0000};
  localparam logic [13:0] E_WA = {3'd5, 11'b000_1000_0101};
  localparam logic [13:0] E_WL = {3'd5, 11'b000_1100_0101};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    u_if.po = 6'd0;
    u_if.halt = 1'b0;
    u_if.imem_ready = 1'b0;
    u_if.dmem_ready = 1'b0;
    u_if.branch_taken = 1'b0;
    tick();
    tick();
    n_vec++;
    if (obs !== 14'd0) begin
      n_err++;
      $display("FAIL reset_strobes got %h want %h", obs, 14'd0);
    end
    n_vec++;
    if ({u_if.illegal_op, u_if.bus_err, u_if.retire_cnt} !== 5'd0) begin
      n_err++;
      $display("FAIL reset_traps got %b want 00000",
               {u_if.illegal_op, u_if.bus_err, u_if.retire_cnt});
    end
  endtask

  task automatic test_alu();
    logic [13:0] e [5];
    e[0] = 14'd0; e[1] = E_F; e[2] = E_D; e[3] = E_X; e[4] = E_WA;
    u_if.po = 6'd31;
    u_if.imem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      n_vec++;
      if (obs !== e[i]) begin
        n_err++;
        $display("FAIL alu_cyc%0d got %h want %h", i, obs, e[i]);
      end
      if (i == 0) rst_n = 1'b1;
      tick();
    end
    n_vec++;
    if ({u_if.state_o, u_if.retire_cnt} !== {3'd1, 3'd1}) begin
      n_err++;
      $display("FAIL alu_end got %h want %h",
               {u_if.state_o, u_if.retire_cnt}, {3'd1, 3'd1});
    end
  endtask

  task automatic test_load();
    logic [13:0] e [8];
    e[0] = E_F; e[1] = E_D; e[2] = E_X;
    e[3] = {3'd4, 11'b000_0001_0000}; e[4] = e[3];
    e[5] = e[3]; e[6] = e[3]; e[7] = E_WL;
    u_if.po = 6'd58;
    for (int i = 0; i < 8; i++) begin
      u_if.dmem_ready = (i == 6);
      #2;
      n_vec++;
      if (obs !== e[i]) begin
        n_err++;
        $display("FAIL load_cyc%0d got %h want %h", i, obs, e[i]);
      end
      tick();
    end
    u_if.dmem_ready = 1'b0;
    n_vec++;
    if ({u_if.state_o, u_if.retire_cnt} !== {3'd1, 3'd2}) begin
      n_err++;
      $display("FAIL load_end got %h want %h",
               {u_if.state_o, u_if.retire_cnt}, {3'd1, 3'd2});
    end
  endtask

  task automatic test_branch();
    logic [13:0] ex [3];
    logic [13:0] exp;
    ex[0] = {3'd3, 11'b001_0010_0101};
    ex[1] = {3'd3, 11'b001_0010_0111};
    ex[2] = {3'd3, 11'b000_0010_0111};
    for (int k = 0; k < 3; k++) begin
      u_if.po = (k == 2) ? 6'd18 : 6'd19;
      u_if.branch_taken = (k == 1);
      for (int i = 0; i < 3; i++) begin
        exp = (i == 0) ? E_F : (i == 1) ? E_D : ex[k];
        #2;
        n_vec++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL br%0d_cyc%0d got %h want %h", k, i, obs, exp);
        end
        tick();
      end
    end
    u_if.branch_taken = 1'b0;
    n_vec++;
    if ({u_if.state_o, u_if.retire_cnt} !== {3'd1, 3'd5}) begin
      n_err++;
      $display("FAIL br_end got %h want %h",
               {u_if.state_o, u_if.retire_cnt}, {3'd1, 3'd5});
    end
  endtask

  task automatic test_store();
    logic [13:0] e [4];
    e[0] = E_F; e[1] = E_D; e[2] = E_X;
    e[3] = {3'd4, 11'b000_0001_1101};
    u_if.po = 6'd36;
    u_if.dmem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_vec++;
      if (obs !== e[i]) begin
        n_err++;
        $display("FAIL st_cyc%0d got %h want %h", i, obs, e[i]);
      end
      tick();
    end
    u_if.dmem_ready = 1'b0;
    n_vec++;
    if ({u_if.state_o, u_if.retire_cnt} !== {3'd1, 3'd6}) begin
      n_err++;
      $display("FAIL st_end got %h want %h",
               {u_if.state_o, u_if.retire_cnt}, {3'd1, 3'd6});
    end
  endtask

  task automatic test_store_timeout();
    logic [13:0] e [7];
    e[0] = E_F; e[1] = E_D; e[2] = E_X;
    e[3] = {3'd4, 11'b000_0001_1000}; e[4] = e[3];
    e[5] = e[3]; e[6] = e[3];
    u_if.po = 6'd37;
    for (int i = 0; i < 7; i++) begin
      #2;
      n_vec++;
      if (obs !== e[i]) begin
        n_err++;
        $display("FAIL sto_cyc%0d got %h want %h", i, obs, e[i]);
      end
      tick();
    end
    #2;
    n_vec++;
    if ({obs, u_if.illegal_op, u_if.bus_err} !== {3'd7, 11'd0, 2'b01}) begin
      n_err++;
      $display("FAIL sto_trap got %h want %h",
               {obs, u_if.illegal_op, u_if.bus_err},
               {3'd7, 11'd0, 2'b01});
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({u_if.state_o, u_if.illegal_op, u_if.bus_err, u_if.retire_cnt}
        !== 8'd0) begin
      n_err++;
      $display("FAIL sto_clear got %h want 00",
               {u_if.state_o, u_if.illegal_op, u_if.bus_err,
                u_if.retire_cnt});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch_wait();
    logic [13:0] e [7];
    e[0] = E_FW; e[1] = E_FW; e[2] = E_FW; e[3] = E_F;
    e[4] = E_D; e[5] = E_X; e[6] = E_WA;
    u_if.po = 6'd31;
    for (int i = 0; i < 7; i++) begin
      u_if.imem_ready = (i == 3);
      #2;
      n_vec++;
      if (obs !== e[i]) begin
        n_err++;
        $display("FAIL fw_cyc%0d got %h want %h", i, obs, e[i]);
      end
      tick();
    end
    n_vec++;
    if ({u_if.state_o, u_if.bus_err, u_if.retire_cnt} !== {3'd1, 1'b0, 3'd1}) begin
      n_err++;
      $display("FAIL fw_end got %h want %h",
               {u_if.state_o, u_if.bus_err, u_if.retire_cnt},
               {3'd1, 1'b0, 3'd1});
    end
  endtask

  task automatic test_fetch_timeout();
    u_if.imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_vec++;
      if (obs !== E_FW) begin
        n_err++;
        $display("FAIL fto_cyc%0d got %h want %h", i, obs, E_FW);
      end
      tick();
    end
    n_vec++;
    if ({u_if.state_o, u_if.illegal_op, u_if.bus_err} !== {3'd7, 2'b01}) begin
      n_err++;
      $display("FAIL fto_trap got %h want %h",
               {u_if.state_o, u_if.illegal_op, u_if.bus_err},
               {3'd7, 2'b01});
    end
  endtask

  task automatic test_illegal();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({u_if.bus_err, u_if.retire_cnt} !== 4'd0) begin
      n_err++;
      $display("FAIL ill_pre got %h want 0",
               {u_if.bus_err, u_if.retire_cnt});
    end
    rst_n = 1'b1;
    tick();
    u_if.po = 6'd7;
    u_if.imem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_vec++;
      if (obs !== ((i == 0) ? E_F : E_D)) begin
        n_err++;
        $display("FAIL ill_cyc%0d got %h want %h", i, obs,
                 (i == 0) ? E_F : E_D);
      end
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      #2;
      n_vec++;
      if ({obs, u_if.illegal_op, u_if.bus_err} !== {3'd7, 11'd0, 2'b10}) begin
        n_err++;
        $display("FAIL ill_hold%0d got %h want %h", i,
                 {obs, u_if.illegal_op, u_if.bus_err},
                 {3'd7, 11'd0, 2'b10});
      end
      tick();
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({u_if.state_o, u_if.illegal_op} !== 4'd0) begin
      n_err++;
      $display("FAIL ill_clear got %h want 0",
               {u_if.state_o, u_if.illegal_op});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_halt_wrap();
    logic [13:0] ea [4];
    logic [2:0]  ec;
    ea[0] = E_F; ea[1] = E_D; ea[2] = E_X; ea[3] = E_WA;
    u_if.halt = 1'b1;
    u_if.imem_ready = 1'b1;
    u_if.po = 6'd31;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) u_if.halt = 1'b0;
      #2;
      n_vec++;
      if (obs !== {(i == 0) ? 3'd1 : 3'd6, 11'd0}) begin
        n_err++;
        $display("FAIL halt_cyc%0d got %h want %h", i, obs,
                 {(i == 0) ? 3'd1 : 3'd6, 11'd0});
      end
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) begin
        #2;
        n_vec++;
        if (obs !== ea[i]) begin
          n_err++;
          $display("FAIL wrap%0d_cyc%0d got %h want %h", k, i, obs, ea[i]);
        end
        tick();
      end
      ec = 3'(k + 1);
      n_vec++;
      if (u_if.retire_cnt !== ec) begin
        n_err++;
        $display("FAIL wrap%0d_cnt got %0d want %0d", k,
                 u_if.retire_cnt, ec);
      end
    end
  endtask

  task automatic test_abort();
    u_if.po = 6'd58;
    tick();
    tick();
    #2;
    n_vec++;
    if (obs !== E_X) begin
      n_err++;
      $display("FAIL abort_exec got %h want %h", obs, E_X);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs !== 14'd0) begin
      n_err++;
      $display("FAIL abort_now got %h want 0", obs);
    end
    tick();
    n_vec++;
    if (obs !== 14'd0) begin
      n_err++;
      $display("FAIL abort_held got %h want 0", obs);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_alu();
    test_load();
    test_branch();
    test_store();
    test_store_timeout();
    test_fetch_wait();
    test_fetch_timeout();
    test_illegal();
    test_halt_wrap();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
